// File: rtl/ms_ff_tester_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : ms_ff_tester_if                                          |
// | Description : Link between the master-slave SR flip-flop tester and    |
// |               the flip-flop under test.                                |
// |                 ff_c    tester -> ff   flip-flop clock                 |
// |                 ff_s_n  tester -> ff   active-low set                  |
// |                 ff_r_n  tester -> ff   active-low reset                |
// |                 q       ff -> tester   flip-flop Q                     |
// |                 qbar    ff -> tester   flip-flop Qbar                  |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
interface ms_ff_tester_if;
  logic ff_c;
  logic ff_s_n;
  logic ff_r_n;
  logic q;
  logic qbar;

  // Tester side
  modport master (output ff_c, ff_s_n, ff_r_n, input q, qbar);
  // Flip-flop side
  modport slave  (input ff_c, ff_s_n, ff_r_n, output q, qbar);
endinterface
`default_nettype wire

// File: rtl/ms_ff_tester.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : ms_ff_tester                                             |
// | Description : Stimulus and checker for a master-slave SR flip-flop     |
// |               (active-low S/R). On start it plays a ROM of {S_n,R_n}   |
// |               vectors, generates the flip-flop clock by division,      |
// |               samples Q/Qbar after each falling edge and compares them |
// |               with a reference model.                                  |
// | Ports       : C        in   system clock, rising edge                  |
// |               rst_n    in   asynchronous active-low reset              |
// |               start    in   one-cycle pulse, begins a run              |
// |               ff       mp   master side of ms_ff_tester_if             |
// |               busy     out  run in progress                            |
// |               done     out  run finished, held until start/reset       |
// |               pass     out  done & err_cnt==0 & chk_cnt!=0             |
// |               err_cnt  out  mismatches, saturating at 255              |
// |               chk_cnt  out  vectors actually checked                   |
// |               vec_idx  out  index of the vector being applied          |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module ms_ff_tester #(
  parameter int                   HALF_PERIOD = 2,
  parameter int                   SETTLE      = 1,
  parameter int                   NUM_VEC     = 7,
  parameter logic [2*NUM_VEC-1:0] VEC         = 14'b11_00_11_01_11_10_11
) (
  input  wire logic         C,
  input  wire logic         rst_n,
  input  wire logic         start,
  ms_ff_tester_if.master    ff,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_cnt,
  output logic [3:0]        chk_cnt,
  output logic [3:0]        vec_idx
);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_LOW    = 3'd1;
  localparam logic [2:0] c_ST_HIGH   = 3'd2;
  localparam logic [2:0] c_ST_SETTLE = 3'd3;
  localparam logic [2:0] c_ST_CHECK  = 3'd4;
  localparam logic [2:0] c_ST_DONE   = 3'd5;

  localparam logic [7:0] c_HP_LAST     = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] c_SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [3:0] c_VEC_LAST    = 4'(NUM_VEC - 1);

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [7:0] r_cnt;

  logic [3:0] r_vec_idx, w_vec_idx_nxt;
  logic [7:0] r_err_cnt, w_err_cnt_nxt;
  logic [3:0] r_chk_cnt, w_chk_cnt_nxt;
  logic       r_exp,     w_exp_nxt;
  logic       r_valid,   w_valid_nxt;
  logic       r_busy,    w_busy_nxt;
  logic       r_done,    w_done_nxt;
  logic       r_pass,    w_pass_nxt;
  logic       r_ff_c,    w_ff_c_nxt;
  logic       r_ff_s_n,  w_ff_s_n_nxt;
  logic       r_ff_r_n,  w_ff_r_n_nxt;

  logic       w_start_ok;
  logic       w_last;
  logic [1:0] w_cur_vec;
  logic [1:0] w_nxt_vec;
  logic       w_drive;

  // Vector ROM lookup; indices past NUM_VEC read as the idle pair 11.
  function automatic logic [1:0] vec_at(input logic [3:0] idx);
    vec_at = 2'b11;
    for (int i = 0; i < NUM_VEC; i++) begin
      if (idx == 4'(i)) vec_at = VEC[2*i +: 2];
    end
  endfunction

  assign w_start_ok = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
  assign w_last     = (r_vec_idx == c_VEC_LAST);
  assign w_cur_vec  = vec_at(r_vec_idx);

  // State register; r_cnt counts cycles spent in the current state.
  always_ff @(posedge C or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) r_cnt <= 8'd0;
      else                        r_cnt <= r_cnt + 8'd1;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE,
      c_ST_DONE:   if (start) w_state_nxt = c_ST_LOW;
      c_ST_LOW:    if (r_cnt == c_HP_LAST) w_state_nxt = c_ST_HIGH;
      c_ST_HIGH:   if (r_cnt == c_HP_LAST) w_state_nxt = c_ST_SETTLE;
      c_ST_SETTLE: if (r_cnt == c_SETTLE_LAST) w_state_nxt = c_ST_CHECK;
      c_ST_CHECK:  w_state_nxt = w_last ? c_ST_DONE : c_ST_LOW;
      default:     w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Output logic: next values of every registered output and of the model.
  always_comb begin
    w_vec_idx_nxt = r_vec_idx;
    w_err_cnt_nxt = r_err_cnt;
    w_chk_cnt_nxt = r_chk_cnt;
    w_exp_nxt     = r_exp;
    w_valid_nxt   = r_valid;
    w_busy_nxt    = r_busy;
    w_done_nxt    = r_done;
    w_pass_nxt    = r_pass;

    if (w_start_ok) begin
      w_vec_idx_nxt = 4'd0;
      w_err_cnt_nxt = 8'd0;
      w_chk_cnt_nxt = 4'd0;
      w_exp_nxt     = 1'b0;
      w_valid_nxt   = 1'b0;
      w_busy_nxt    = 1'b1;
      w_done_nxt    = 1'b0;
      w_pass_nxt    = 1'b0;
    end else if (r_state == c_ST_CHECK) begin
      case (w_cur_vec)
        2'b10:   begin w_exp_nxt = 1'b0; w_valid_nxt = 1'b1; end
        2'b01:   begin w_exp_nxt = 1'b1; w_valid_nxt = 1'b1; end
        2'b00:   w_valid_nxt = 1'b0;
        default: ;
      endcase
      if (w_valid_nxt) begin
        w_chk_cnt_nxt = r_chk_cnt + 4'd1;
        if (((ff.q != w_exp_nxt) || (ff.qbar == w_exp_nxt)) && (r_err_cnt != 8'hFF))
          w_err_cnt_nxt = r_err_cnt + 8'd1;
      end
      if (w_last) begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b1;
        // Uses this cycle's counts so pass lines up with done.
        w_pass_nxt = (w_err_cnt_nxt == 8'd0) && (w_chk_cnt_nxt != 4'd0);
      end else begin
        w_vec_idx_nxt = r_vec_idx + 4'd1;
      end
    end

    w_nxt_vec    = vec_at(w_vec_idx_nxt);
    w_drive      = (w_state_nxt == c_ST_LOW)    || (w_state_nxt == c_ST_HIGH) ||
                   (w_state_nxt == c_ST_SETTLE) || (w_state_nxt == c_ST_CHECK);
    w_ff_c_nxt   = (w_state_nxt == c_ST_HIGH);
    w_ff_s_n_nxt = w_drive ? w_nxt_vec[1] : 1'b1;
    w_ff_r_n_nxt = w_drive ? w_nxt_vec[0] : 1'b1;
  end

  always_ff @(posedge C or negedge rst_n) begin
    if (!rst_n) begin
      r_vec_idx <= 4'd0;
      r_err_cnt <= 8'd0;
      r_chk_cnt <= 4'd0;
      r_exp     <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_ff_c    <= 1'b0;
      r_ff_s_n  <= 1'b1;
      r_ff_r_n  <= 1'b1;
    end else begin
      r_vec_idx <= w_vec_idx_nxt;
      r_err_cnt <= w_err_cnt_nxt;
      r_chk_cnt <= w_chk_cnt_nxt;
      r_exp     <= w_exp_nxt;
      r_valid   <= w_valid_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_pass    <= w_pass_nxt;
      r_ff_c    <= w_ff_c_nxt;
      r_ff_s_n  <= w_ff_s_n_nxt;
      r_ff_r_n  <= w_ff_r_n_nxt;
    end
  end

  assign ff.ff_c   = r_ff_c;
  assign ff.ff_s_n = r_ff_s_n;
  assign ff.ff_r_n = r_ff_r_n;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_cnt   = r_err_cnt;
  assign chk_cnt   = r_chk_cnt;
  assign vec_idx   = r_vec_idx;

endmodule
`default_nettype wire

// File: tb/tb_ms_ff_tester.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_ms_ff_tester                                          |
// | Description : Bench for ms_ff_tester. Unit A uses default timing with  |
// |               a selectable flip-flop fault; unit B uses HALF_PERIOD=1, |
// |               SETTLE=2 with a correct flip-flop.                       |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_ms_ff_tester;

  localparam int          c_NUM = 7;
  localparam logic [13:0] c_VEC = 14'b11_00_11_01_11_10_11;
  localparam int          c_HA = 2, c_SA = 1, c_HB = 1, c_SB = 2;
  localparam int          c_PA = 2*c_HA + c_SA + 1;
  localparam int          c_PB = 2*c_HB + c_SB + 1;

  logic C = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  int   mode_a = 0;     // 0 good ff, 1 q stuck 0, 2 q tied to qbar

  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [7:0] err_a, err_b;
  logic [3:0] chk_a, chk_b, vi_a, vi_b;

  int tests = 0, fails = 0;
  bit cmp_en = 1'b0;

  ms_ff_tester_if ifa();
  ms_ff_tester_if ifb();

  always #5 C = ~C;

  ms_ff_tester u_a (
    .C(C), .rst_n(rst_n), .start(start_a), .ff(ifa),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_cnt(err_a), .chk_cnt(chk_a), .vec_idx(vi_a)
  );

  ms_ff_tester #(.HALF_PERIOD(c_HB), .SETTLE(c_SB)) u_b (
    .C(C), .rst_n(rst_n), .start(start_b), .ff(ifb),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_cnt(err_b), .chk_cnt(chk_b), .vec_idx(vi_b)
  );

  // Behavioural master-slave SR flip-flops: master latches on rising C,
  // slave copies master on falling C.
  logic fa_mq = 1'b0, fa_mqb = 1'b1, fa_q = 1'b0, fa_qb = 1'b1;
  logic fb_mq = 1'b0, fb_mqb = 1'b1, fb_q = 1'b0, fb_qb = 1'b1;

  always @(posedge ifa.ff_c)
    case ({ifa.ff_s_n, ifa.ff_r_n})
      2'b10:   begin fa_mq = 1'b0; fa_mqb = 1'b1; end
      2'b01:   begin fa_mq = 1'b1; fa_mqb = 1'b0; end
      2'b00:   begin fa_mq = 1'b1; fa_mqb = 1'b1; end
      default: ;
    endcase
  always @(negedge ifa.ff_c) begin fa_q = fa_mq; fa_qb = fa_mqb; end

  always @(posedge ifb.ff_c)
    case ({ifb.ff_s_n, ifb.ff_r_n})
      2'b10:   begin fb_mq = 1'b0; fb_mqb = 1'b1; end
      2'b01:   begin fb_mq = 1'b1; fb_mqb = 1'b0; end
      2'b00:   begin fb_mq = 1'b1; fb_mqb = 1'b1; end
      default: ;
    endcase
  always @(negedge ifb.ff_c) begin fb_q = fb_mq; fb_qb = fb_mqb; end

  assign ifa.q    = (mode_a == 1) ? 1'b0 : fa_q;
  assign ifa.qbar = (mode_a == 1) ? 1'b1 : (mode_a == 2) ? fa_q : fa_qb;
  assign ifb.q    = fb_q;
  assign ifb.qbar = fb_qb;

  // ---------------- reference model ----------------
  // Per vector: is it checked, and what Q is expected.
  bit vld [c_NUM];
  bit exq [c_NUM];

  function automatic logic [1:0] vec_of(input int i);
    logic [13:0] v;
    v = c_VEC;
    return v[2*i +: 2];
  endfunction

  initial begin
    bit v, e;
    v = 1'b0; e = 1'b0;
    for (int i = 0; i < c_NUM; i++) begin
      case (vec_of(i))
        2'b10: begin v = 1'b1; e = 1'b0; end
        2'b01: begin v = 1'b1; e = 1'b1; end
        2'b00: v = 1'b0;
        default: ;
      endcase
      vld[i] = v;
      exq[i] = e;
    end
  end

  function automatic int cnt_chk(input int upto);
    int c = 0;
    for (int j = 0; j < upto; j++) if (vld[j]) c++;
    return c;
  endfunction

  function automatic int cnt_err(input int upto, input int md);
    int c = 0;
    for (int j = 0; j < upto; j++)
      if (vld[j] && ((md == 2) || (md == 1 && exq[j]))) c++;
    return c;
  endfunction

  // Run trackers: cycles elapsed since the accepted start edge.
  bit st_a = 1'b0, st_b = 1'b0;
  int n_a = 0, n_b = 0, md_a = 0;

  always @(posedge C or negedge rst_n) begin
    if (!rst_n) begin
      st_a <= 1'b0; n_a <= 0; st_b <= 1'b0; n_b <= 0;
    end else begin
      if (start_a && !(st_a && n_a < c_NUM*c_PA)) begin
        st_a <= 1'b1; n_a <= 0; md_a <= mode_a;
      end else if (st_a) n_a <= n_a + 1;
      if (start_b && !(st_b && n_b < c_NUM*c_PB)) begin
        st_b <= 1'b1; n_b <= 0;
      end else if (st_b) n_b <= n_b + 1;
    end
  end

  task automatic check_one(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input string tag, input bit st, input int n,
                           input int h, input int s, input int md,
                           input logic a_busy, input logic a_done, input logic a_pass,
                           input logic [7:0] a_err, input logic [3:0] a_chk,
                           input logic [3:0] a_vi, input logic a_c,
                           input logic a_sn, input logic a_rn);
    int p_len, run_len, vi, ph, e_chk, e_err;
    bit e_busy, e_done, e_pass, e_c;
    logic [1:0] e_sr;
    p_len = 2*h + s + 1;
    run_len = c_NUM * p_len;
    e_busy = 0; e_done = 0; e_pass = 0; e_c = 0; e_sr = 2'b11;
    vi = 0; e_chk = 0; e_err = 0;
    if (st && n < run_len) begin
      vi = n / p_len; ph = n % p_len;
      e_busy = 1;
      e_c = (ph >= h) && (ph < 2*h);
      e_sr = vec_of(vi);
      e_chk = cnt_chk(vi);
      e_err = cnt_err(vi, md);
    end else if (st) begin
      vi = c_NUM - 1;
      e_done = 1;
      e_chk = cnt_chk(c_NUM);
      e_err = cnt_err(c_NUM, md);
      e_pass = (e_err == 0) && (e_chk != 0);
    end
    check_one({tag, ".busy"},    int'(a_busy), int'(e_busy));
    check_one({tag, ".done"},    int'(a_done), int'(e_done));
    check_one({tag, ".pass"},    int'(a_pass), int'(e_pass));
    check_one({tag, ".err_cnt"}, int'(a_err),  e_err);
    check_one({tag, ".chk_cnt"}, int'(a_chk),  e_chk);
    check_one({tag, ".vec_idx"}, int'(a_vi),   vi);
    check_one({tag, ".ff_c"},    int'(a_c),    int'(e_c));
    check_one({tag, ".ff_s_n"},  int'(a_sn),   int'(e_sr[1]));
    check_one({tag, ".ff_r_n"},  int'(a_rn),   int'(e_sr[0]));
  endtask

  always @(negedge C) begin
    if (cmp_en) begin
      check_dut("A", st_a, n_a, c_HA, c_SA, md_a, busy_a, done_a, pass_a,
                err_a, chk_a, vi_a, ifa.ff_c, ifa.ff_s_n, ifa.ff_r_n);
      check_dut("B", st_b, n_b, c_HB, c_SB, 0, busy_b, done_b, pass_b,
                err_b, chk_b, vi_b, ifb.ff_c, ifb.ff_s_n, ifb.ff_r_n);
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse(input bit a, input bit b);
    @(negedge C);
    start_a = a; start_b = b;
    @(negedge C);
    start_a = 1'b0; start_b = 1'b0;
  endtask

  // Cycles from the start edge until done is seen; -1 if the bound expires.
  task automatic wait_done(output int la, output int lb);
    la = -1; lb = -1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(posedge C); #1;
      if (done_a && la < 0) la = cyc;
      if (done_b && lb < 0) lb = cyc;
      if (la >= 0 && lb >= 0) break;
    end
  endtask

  initial begin
    int la, lb;
    bit found;

    // Reset state
    repeat (3) @(negedge C);
    cmp_en = 1'b1;
    check_one("rst.busy", int'(busy_a), 0);
    check_one("rst.ff_s_n", int'(ifa.ff_s_n), 1);
    check_one("rst.vec_idx", int'(vi_a), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge C);

    // 1 + 6: both units, good flip-flops
    pulse(1'b1, 1'b1);
    wait_done(la, lb);
    check_one("t1.latency_a", la, 42);
    check_one("t6.latency_b", lb, 35);
    check_one("t1.chk_cnt", int'(chk_a), 4);
    check_one("t1.err_cnt", int'(err_a), 0);
    check_one("t1.pass", int'(pass_a), 1);
    check_one("t6.pass", int'(pass_b), 1);

    // 2: q stuck at 0
    mode_a = 1;
    pulse(1'b1, 1'b0);
    wait_done(la, lb);
    check_one("t2.latency", la, 42);
    check_one("t2.err_cnt", int'(err_a), 2);
    check_one("t2.pass", int'(pass_a), 0);

    // 3: q tied to qbar
    mode_a = 2;
    pulse(1'b1, 1'b0);
    wait_done(la, lb);
    check_one("t3.err_cnt", int'(err_a), 4);
    check_one("t3.chk_cnt", int'(chk_a), 4);
    check_one("t3.pass", int'(pass_a), 0);

    // 4: reset during the HIGH phase of vector 3
    mode_a = 0;
    pulse(1'b1, 1'b0);
    found = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(posedge C); #1;
      if (vi_a == 4'd3 && ifa.ff_c) begin found = 1'b1; break; end
    end
    check_one("t4.reached_v3_high", int'(found), 1);
    #2 rst_n = 1'b0;
    #1;
    check_one("t4.busy", int'(busy_a), 0);
    check_one("t4.ff_c", int'(ifa.ff_c), 0);
    check_one("t4.vec_idx", int'(vi_a), 0);
    check_one("t4.chk_cnt", int'(chk_a), 0);
    @(negedge C);
    rst_n = 1'b1;
    pulse(1'b1, 1'b0);
    wait_done(la, lb);
    check_one("t4.latency", la, 42);
    check_one("t4.pass", int'(pass_a), 1);

    // 5: start while busy (mid-run and in the final CHECK cycle) is ignored
    pulse(1'b1, 1'b0);
    la = -1;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(negedge C);
      start_a = (cyc == 10) || (cyc == 41);
      if (done_a && la < 0) la = cyc;
    end
    start_a = 1'b0;
    check_one("t5.latency", la, 42);
    check_one("t5.busy", int'(busy_a), 0);
    check_one("t5.chk_cnt", int'(chk_a), 4);

    // 5: start from DONE clears and repeats
    pulse(1'b1, 1'b0);
    check_one("t5.restart_done", int'(done_a), 0);
    check_one("t5.restart_busy", int'(busy_a), 1);
    check_one("t5.restart_chk", int'(chk_a), 0);
    wait_done(la, lb);
    check_one("t5.rerun_latency", la, 42);
    check_one("t5.rerun_pass", int'(pass_a), 1);

    repeat (3) @(negedge C);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
